// File: rtl/pulse_mux.sv
// pulse_mux
// Registered source selector for the microwave encoder path. Chooses between
// an internal divided timing tick and one of N_CH external key/sensor
// channels. Each channel is synchronised and debounced, and can be delivered
// either as a level or as a one-shot pulse on its debounced rising edge.
// Changing the select forces one blanking cycle so the output never glitches
// between sources.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   sel     - 0 = internal tick, k = channel k-1 (1..N_CH), above N_CH = invalid
//   mode    - 0 = level pass-through, 1 = one-shot on rising edge (channels only)
//   din     - raw asynchronous channel inputs
//   out     - registered selected output
//   sel_err - registered, high while the registered select is out of range
module pulse_mux #(
   parameter int N_CH        = 4,
   parameter int SEL_W       = 3,
   parameter int DIV         = 10,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] sel,
   input  logic             mode,
   input  logic [N_CH-1:0]  din,
   output logic             out,
   output logic             sel_err
);

   // +1 keeps the counter at least one bit wide when DB_CYCLES is 1
   localparam int CNT_W  = $clog2(DB_CYCLES + 1);
   localparam int TCNT_W = $clog2(DIV);

   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DB_CYCLES - 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(DIV - 1);
   localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(N_CH);

   logic [SYNC_STAGES-1:0] sync_q [N_CH];
   logic [SYNC_STAGES-1:0] sync_d [N_CH];
   logic [N_CH-1:0]        sync_s;

   logic [CNT_W-1:0]       cnt_q [N_CH];
   logic [CNT_W-1:0]       cnt_d [N_CH];

   logic [N_CH-1:0]        db_q;
   logic [N_CH-1:0]        db_d;
   logic [N_CH-1:0]        db_prev_q;
   logic [N_CH-1:0]        db_prev_d;
   logic [N_CH-1:0]        rise;

   logic [TCNT_W-1:0]      tcnt_q;
   logic [TCNT_W-1:0]      tcnt_d;
   logic                   tick;

   logic [SEL_W-1:0]       sel_q;
   logic [SEL_W-1:0]       sel_d;
   logic                   out_q;
   logic                   out_d;
   logic                   sel_err_q;
   logic                   sel_err_d;
   logic                   src;

   // Last synchroniser stage is the MSB of each channel's shift register
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         sync_s[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   // Synchroniser shift and debounce: a new value is accepted only after the
   // synced input has disagreed with the stable value for DB_CYCLES edges in a
   // row; any return to agreement restarts the count.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], din[i]};
         db_d[i]   = db_q[i];
         cnt_d[i]  = '0;
         if (sync_s[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_d[i] = sync_s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      db_prev_d = db_q;
      rise      = db_q & ~db_prev_q;
   end

   // Free-running tick divider, independent of the select
   always_comb begin
      tick   = (tcnt_q == TCNT_MAX);
      tcnt_d = tick ? '0 : tcnt_q + TCNT_W'(1);
   end

   // Source mux and blanking: a select change spends one cycle driving 0
   // while sel_q catches up, so the old and new sources never meet.
   always_comb begin
      src = 1'b0;
      if (sel_q == '0) begin
         src = tick;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (sel_q == SEL_W'(i + 1)) begin
               src = mode ? rise[i] : db_q[i];
            end
         end
      end

      sel_d     = sel;
      sel_err_d = (sel_q > SEL_MAX);
      out_d     = (sel != sel_q) ? 1'b0 : src;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            sync_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         db_q      <= '0;
         db_prev_q <= '0;
         tcnt_q    <= '0;
         sel_q     <= '0;
         out_q     <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            sync_q[i] <= sync_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         tcnt_q    <= tcnt_d;
         sel_q     <= sel_d;
         out_q     <= out_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign out     = out_q;
   assign sel_err = sel_err_q;

endmodule
